// File: rtl/button_event_gen.sv
// Turns a debounced button level into single-cycle press, release, long-press
// and auto-repeat events. All outputs are registered.
module button_event_gen #(
  parameter int unsigned c_HOLD_LIMIT   = 12500000,
  parameter int unsigned c_REPEAT_LIMIT = 2500000,
  parameter int unsigned c_CNT_WIDTH    = 24
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch,
  output logic       o_Press,
  output logic       o_Release,
  output logic       o_Long,
  output logic       o_Repeat,
  output logic       o_Held,
  output logic [1:0] o_State
);

  typedef enum logic [1:0] {
    LOCKOUT = 2'd0,
    IDLE    = 2'd1,
    PRESSED = 2'd2,
    HELD    = 2'd3
  } state_t;

  localparam logic [c_CNT_WIDTH-1:0] HOLD_LAST   = c_CNT_WIDTH'(c_HOLD_LIMIT - 1);
  localparam logic [c_CNT_WIDTH-1:0] REPEAT_LAST = c_CNT_WIDTH'(c_REPEAT_LIMIT - 1);
  localparam logic [c_CNT_WIDTH-1:0] CNT_ONE     = c_CNT_WIDTH'(1);

  state_t                 state, state_next;
  logic [c_CNT_WIDTH-1:0] cnt, cnt_next;
  logic                   press_next, release_next, long_next, repeat_next, held_next;

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    press_next   = 1'b0;
    release_next = 1'b0;
    long_next    = 1'b0;
    repeat_next  = 1'b0;

    case (state)
      LOCKOUT: begin
        if (!i_Switch) state_next = IDLE;
      end
      IDLE: begin
        if (i_Switch) begin
          state_next = PRESSED;
          press_next = 1'b1;
          cnt_next   = '0;
        end
      end
      PRESSED: begin
        // Release is tested first so it wins over a coincident long-press.
        if (!i_Switch) begin
          state_next   = IDLE;
          release_next = 1'b1;
          cnt_next     = '0;
        end else if (cnt == HOLD_LAST) begin
          state_next = HELD;
          long_next  = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!i_Switch) begin
          state_next   = IDLE;
          release_next = 1'b1;
          cnt_next     = '0;
        end else if (c_REPEAT_LIMIT != 0) begin
          if (cnt == REPEAT_LAST) begin
            repeat_next = 1'b1;
            cnt_next    = '0;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
      end
      default: begin
        state_next = LOCKOUT;
        cnt_next   = '0;
      end
    endcase

    held_next = (state_next == PRESSED) || (state_next == HELD);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state     <= LOCKOUT;
      cnt       <= '0;
      o_Press   <= 1'b0;
      o_Release <= 1'b0;
      o_Long    <= 1'b0;
      o_Repeat  <= 1'b0;
      o_Held    <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      o_Press   <= press_next;
      o_Release <= release_next;
      o_Long    <= long_next;
      o_Repeat  <= repeat_next;
      o_Held    <= held_next;
    end
  end

  assign o_State = state;

endmodule
